// File: rtl/fmul_rr_scheduler.sv
// Round-robin scheduler sharing one combinational FP32 multiplier between two requesters.
// Optional FMUL_ZERO_BYPASS_EN: a zero/denormal operand forces a signed-zero result.

module FloatMultiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  logic [47:0] prod;
  logic        norm;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        rnd;
  logic [23:0] mant_rnd;
  logic [9:0]  exp_sum;

  assign prod = {1'b1, a[22:0]} * {1'b1, b[22:0]};
  assign norm = prod[47];

  // Round to nearest even; a rounding carry out of the mantissa bumps the exponent.
  assign mant     = norm ? prod[46:24] : prod[45:23];
  assign guard    = norm ? prod[23] : prod[22];
  assign sticky   = norm ? |prod[22:0] : |prod[21:0];
  assign rnd      = guard & (sticky | mant[0]);
  assign mant_rnd = {1'b0, mant} + {23'b0, rnd};
  assign exp_sum  = {2'b0, a[30:23]} + {2'b0, b[30:23]} + {9'b0, norm}
                  + {9'b0, mant_rnd[23]} - 10'd127;

  assign p = {a[31] ^ b[31], exp_sum[7:0], mant_rnd[22:0]};

endmodule

module fmul_rr_scheduler #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req0_Valid,
  output logic        Req0_Ready,
  input  logic [31:0] Req0_A,
  input  logic [31:0] Req0_B,
  input  logic        Req1_Valid,
  output logic        Req1_Ready,
  input  logic [31:0] Req1_A,
  input  logic [31:0] Req1_B,
  output logic        Rsp_Valid,
  input  logic        Rsp_Ready,
  output logic        Rsp_Id,
  output logic [31:0] Rsp_Result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic        id_reg;
  logic        ptr;
  logic [3:0]  cnt;
  logic [31:0] mul_out;
  logic [31:0] result_next;
  logic        grant0;
  logic        grant1;

  // Under contention the pointer side wins; a lone requester always wins.
  assign grant0 = Req0_Valid && (!Req1_Valid || !ptr);
  assign grant1 = Req1_Valid && (!Req0_Valid || ptr);

  assign Req0_Ready = (state == IDLE) && grant0;
  assign Req1_Ready = (state == IDLE) && grant1;

  FloatMultiplier u_mul (
    .a (a_reg),
    .b (b_reg),
    .p (mul_out)
  );

`ifdef FMUL_ZERO_BYPASS_EN
  assign result_next = (a_reg[30:23] == 8'd0 || b_reg[30:23] == 8'd0)
                     ? {a_reg[31] ^ b_reg[31], 31'b0} : mul_out;
`else
  assign result_next = mul_out;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      id_reg     <= 1'b0;
      ptr        <= 1'b0;
      cnt        <= '0;
      Rsp_Valid  <= 1'b0;
      Rsp_Id     <= 1'b0;
      Rsp_Result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_reg  <= grant1 ? Req1_A : Req0_A;
            b_reg  <= grant1 ? Req1_B : Req0_B;
            id_reg <= grant1;
            ptr    <= ~grant1;
            cnt    <= 4'(MUL_CYCLES - 1);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            Rsp_Result <= result_next;
            Rsp_Id     <= id_reg;
            Rsp_Valid  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // Response stays put until taken; the next grant waits one more cycle.
          if (Rsp_Ready) begin
            Rsp_Valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
